// File: rtl/calc_pkg.sv
// Shared calculator types: normalized number format, keypad codes and entry FSM states.
package calc_pkg;

  localparam int unsigned NumDigits = 8;
  localparam int unsigned SigWidth  = 4 * NumDigits;
  localparam int unsigned ExpWidth  = 8;
  localparam int unsigned CntWidth  = $clog2(NumDigits) + 1;

  typedef logic [3:0] bcd_t;

  // value = 0.d[N-1]..d[0] x 10^exponent, d[N-1] in sig[SigWidth-1 -: 4]
  typedef struct packed {
    logic                sign;
    logic                error;
    logic [ExpWidth-1:0] exponent;
    logic [SigWidth-1:0] sig;
  } num_t;

  typedef enum logic [3:0] {
    KEY_0     = 4'd0,
    KEY_1     = 4'd1,
    KEY_2     = 4'd2,
    KEY_3     = 4'd3,
    KEY_4     = 4'd4,
    KEY_5     = 4'd5,
    KEY_6     = 4'd6,
    KEY_7     = 4'd7,
    KEY_8     = 4'd8,
    KEY_9     = 4'd9,
    KEY_POINT = 4'd10,
    KEY_NEG   = 4'd11,
    KEY_CLEAR = 4'd12,
    KEY_BKSP  = 4'd13,
    KEY_ENTER = 4'd14
  } key_t;

  typedef enum logic [1:0] {
    S_ENTRY     = 2'd0,
    S_NORMALIZE = 2'd1,
    S_OUTPUT    = 2'd2
  } entry_state_e;

endpackage

// File: rtl/num_entry.sv
// Keypad operand builder: accumulates a decimal entry, left-justifies it on ENTER and
// offers the normalized operand on a valid/ready port.
module num_entry
  import calc_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  key_t                key_i,
  input  logic                key_valid_i,
  output logic                key_ready_o,
  output num_t                num_o,
  output logic                num_valid_o,
  input  logic                num_ready_i,
  output logic [CntWidth-1:0] count_o
);

  entry_state_e        state_q, state_d;
  logic [SigWidth-1:0] sig_q, sig_d;
  logic                sign_q, sign_d;
  logic                pt_q, pt_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [CntWidth-1:0] intd_q, intd_d;
  logic [CntWidth-1:0] shift_q, shift_d;
  num_t                num_q, num_d;
  logic                num_valid_q, num_valid_d;
  logic                key_ready_q, key_ready_d;
  bcd_t                digit;

  assign digit = bcd_t'(key_i);

  always_comb begin
    state_d  = state_q;
    sig_d    = sig_q;
    sign_d   = sign_q;
    pt_d     = pt_q;
    cnt_d    = cnt_q;
    intd_d   = intd_q;
    shift_d  = shift_q;
    num_d    = num_q;

    unique case (state_q)
      S_ENTRY: begin
        if (key_valid_i && key_ready_q) begin
          case (key_i)
            KEY_0, KEY_1, KEY_2, KEY_3, KEY_4,
            KEY_5, KEY_6, KEY_7, KEY_8, KEY_9: begin
              // Full buffer drops the digit; a leading integer zero carries no value.
              if (cnt_q != CntWidth'(NumDigits) &&
                  !(digit == 4'd0 && cnt_q == '0 && !pt_q)) begin
                sig_d = {sig_q[SigWidth-5:0], digit};
                cnt_d = cnt_q + CntWidth'(1);
                if (!pt_q) intd_d = intd_q + CntWidth'(1);
              end
            end
            KEY_POINT: pt_d   = 1'b1;
            KEY_NEG:   sign_d = ~sign_q;
            KEY_CLEAR: begin
              sig_d  = '0;
              sign_d = 1'b0;
              pt_d   = 1'b0;
              cnt_d  = '0;
              intd_d = '0;
            end
            KEY_BKSP: begin
              // With no fraction digits yet, backspace removes the point itself.
              if (pt_q && cnt_q == intd_q) begin
                pt_d = 1'b0;
              end else if (cnt_q != '0) begin
                sig_d = {4'h0, sig_q[SigWidth-1:4]};
                cnt_d = cnt_q - CntWidth'(1);
                if (!pt_q) intd_d = intd_q - CntWidth'(1);
              end
            end
            KEY_ENTER: begin
              shift_d = cnt_q;
              state_d = S_NORMALIZE;
            end
            default: ;
          endcase
        end
      end

      S_NORMALIZE: begin
        if (shift_q != CntWidth'(NumDigits)) begin
          sig_d   = {sig_q[SigWidth-5:0], 4'h0};
          shift_d = shift_q + CntWidth'(1);
        end else begin
          state_d        = S_OUTPUT;
          num_d.sign     = sign_q && (sig_q != '0);
          num_d.error    = 1'b0;
          num_d.exponent = ExpWidth'(intd_q);
          num_d.sig      = sig_q;
        end
      end

      S_OUTPUT: begin
        if (num_valid_q && num_ready_i) begin
          state_d = S_ENTRY;
          sig_d   = '0;
          sign_d  = 1'b0;
          pt_d    = 1'b0;
          cnt_d   = '0;
          intd_d  = '0;
          shift_d = '0;
          num_d   = '0;
        end
      end

      default: state_d = S_ENTRY;
    endcase

    num_valid_d = (state_d == S_OUTPUT);
    key_ready_d = (state_d == S_ENTRY);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_ENTRY;
      sig_q       <= '0;
      sign_q      <= 1'b0;
      pt_q        <= 1'b0;
      cnt_q       <= '0;
      intd_q      <= '0;
      shift_q     <= '0;
      num_q       <= '0;
      num_valid_q <= 1'b0;
      key_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      sig_q       <= sig_d;
      sign_q      <= sign_d;
      pt_q        <= pt_d;
      cnt_q       <= cnt_d;
      intd_q      <= intd_d;
      shift_q     <= shift_d;
      num_q       <= num_d;
      num_valid_q <= num_valid_d;
      key_ready_q <= key_ready_d;
    end
  end

  assign key_ready_o = key_ready_q;
  assign num_o       = num_q;
  assign num_valid_o = num_valid_q;
  assign count_o     = cnt_q;

endmodule
